// File: rtl/counter_updown_mod.sv
// Reloadable up/down modulo counter with compare match and load-range checking.
// Define COUNTER_SAT_EN to build the saturating variant (holds at the bounds, WRAP tied low).
module counter_updown_mod #(
  parameter int     WIDTH     = 8,
  parameter longint MODULUS   = 256,
  parameter longint RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENA,
  input  logic             LOAD,
  input  logic             UP_DN,
  input  logic [WIDTH-1:0] DATA,
  input  logic [WIDTH-1:0] CMP,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             WRAP,
  output logic             MATCH,
  output logic             LOAD_ERR
);

  // One spare bit keeps MODULUS = 2**WIDTH representable without aliasing.
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] RST_EXT = (WIDTH+1)'(RESET_VAL);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_q;
  logic [WIDTH:0] cnt_d;
  logic [WIDTH:0] data_ext;
  logic [WIDTH:0] cmp_ext;
  logic           at_max;
  logic           at_zero;
  logic           wrap_evt_q;
  logic           wrap_evt_d;
  logic           wrap_q;
  logic           err_q;
  logic           err_d;

  assign data_ext = {1'b0, DATA};
  assign cmp_ext  = {1'b0, CMP};
  assign at_max   = (cnt_q == MAX_EXT);
  assign at_zero  = (cnt_q == '0);

  assign COUNT    = cnt_q[WIDTH-1:0];
  assign TC       = ENA & (UP_DN ? at_max : at_zero);
  assign MATCH    = (cmp_ext == cnt_q) && (cmp_ext < MOD_EXT);
  assign WRAP     = wrap_q;
  assign LOAD_ERR = err_q;

  always_comb begin
    cnt_d      = cnt_q;
    wrap_evt_d = 1'b0;
    err_d      = err_q;
    if (LOAD) begin
      if (data_ext < MOD_EXT) begin
        cnt_d = data_ext;
        err_d = 1'b0;
      end else begin
        cnt_d = MAX_EXT;
        err_d = 1'b1;
      end
    end else if (ENA) begin
      if (UP_DN) begin
        if (at_max) begin
`ifdef COUNTER_SAT_EN
          cnt_d = MAX_EXT;
`else
          cnt_d      = '0;
          wrap_evt_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + ONE_EXT;
        end
      end else begin
        if (at_zero) begin
`ifdef COUNTER_SAT_EN
          cnt_d = '0;
`else
          cnt_d      = MAX_EXT;
          wrap_evt_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - ONE_EXT;
        end
      end
    end
  end

  // The wrap event is staged once more so WRAP lands one cycle after the wrapped COUNT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q      <= RST_EXT;
      wrap_evt_q <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_evt_q <= wrap_evt_d;
      wrap_q     <= wrap_evt_q;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: a MODULUS=10 instance driven from a vector table (modulo build)
// and a full-range 4-bit instance exercised by a hand-written sequence in either build.
module tb_counter_updown_mod;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       a_reset, a_ena, a_load, a_up_dn;
  logic [7:0] a_data, a_cmp, a_count;
  logic       a_tc, a_wrap, a_match, a_err;

  logic       b_reset, b_ena, b_load, b_up_dn;
  logic [3:0] b_data, b_cmp, b_count;
  logic       b_tc, b_wrap, b_match, b_err;

  counter_updown_mod #(.WIDTH(8), .MODULUS(10), .RESET_VAL(3)) u_mod10 (
    .CLK(CLK), .RESET(a_reset), .ENA(a_ena), .LOAD(a_load), .UP_DN(a_up_dn),
    .DATA(a_data), .CMP(a_cmp), .COUNT(a_count), .TC(a_tc), .WRAP(a_wrap),
    .MATCH(a_match), .LOAD_ERR(a_err)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u_full4 (
    .CLK(CLK), .RESET(b_reset), .ENA(b_ena), .LOAD(b_load), .UP_DN(b_up_dn),
    .DATA(b_data), .CMP(b_cmp), .COUNT(b_count), .TC(b_tc), .WRAP(b_wrap),
    .MATCH(b_match), .LOAD_ERR(b_err)
  );

  // Inputs for one edge, and the outputs expected once that edge has happened
  // (inputs still held, so TC and MATCH reflect the new COUNT).
  typedef struct {
    bit         sel;
    bit         rst, ld, ena, ud;
    logic [7:0] data, cmp;
    logic [7:0] count;
    bit         tc, wrap, match, err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   vec_idx = 0;

  function automatic vec_t mk(bit sel, bit rst, bit ld, bit ena, bit ud,
                              logic [7:0] data, logic [7:0] cmp, logic [7:0] count,
                              bit tc, bit wrap, bit match, bit err);
    vec_t v;
    v.sel = sel; v.rst = rst; v.ld = ld; v.ena = ena; v.ud = ud;
    v.data = data; v.cmp = cmp; v.count = count;
    v.tc = tc; v.wrap = wrap; v.match = match; v.err = err;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL vec%0d %s: got %0h expected %0h", vec_idx, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_reset = 1'b0; a_load = 1'b0; a_ena = 1'b0;
    b_reset = 1'b0; b_load = 1'b0; b_ena = 1'b0;
    if (!v.sel) begin
      a_reset = v.rst; a_load = v.ld; a_ena = v.ena; a_up_dn = v.ud;
      a_data = v.data; a_cmp = v.cmp;
    end else begin
      b_reset = v.rst; b_load = v.ld; b_ena = v.ena; b_up_dn = v.ud;
      b_data = v.data[3:0]; b_cmp = v.cmp[3:0];
    end
    exp_q.push_back(v);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL vec%0d scoreboard: got empty queue expected an entry", vec_idx);
      return;
    end
    e = exp_q.pop_front();
    if (!e.sel) begin
      checkField("COUNT",    32'(a_count), 32'(e.count));
      checkField("TC",       32'(a_tc),    32'(e.tc));
      checkField("WRAP",     32'(a_wrap),  32'(e.wrap));
      checkField("MATCH",    32'(a_match), 32'(e.match));
      checkField("LOAD_ERR", 32'(a_err),   32'(e.err));
    end else begin
      checkField("COUNT4",    32'(b_count), 32'(e.count));
      checkField("TC4",       32'(b_tc),    32'(e.tc));
      checkField("WRAP4",     32'(b_wrap),  32'(e.wrap));
      checkField("MATCH4",    32'(b_match), 32'(e.match));
      checkField("LOAD_ERR4", 32'(b_err),   32'(e.err));
    end
    vec_idx++;
  endtask

  task automatic step(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    a_reset = 1'b1; a_ena = 1'b0; a_load = 1'b0; a_up_dn = 1'b1; a_data = '0; a_cmp = 8'hFF;
    b_reset = 1'b1; b_ena = 1'b0; b_load = 1'b0; b_up_dn = 1'b1; b_data = '0; b_cmp = '0;

    //             sel rst ld en ud data   cmp    count tc wr mt er
    // Reset and idle hold
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'd0,  8'hFF, 8'd3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'd0,  8'hFF, 8'd3, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 8'd0, 8'hFF, 8'd3, 0, 0, 0, 0));
    // Up wrap from 7
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'd7,  8'hFF, 8'd7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd8, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd9, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd2, 0, 0, 0, 0));
    // Down wrap, then direction flip at 9
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'd1,  8'hFF, 8'd1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,  8'hFF, 8'd0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,  8'hFF, 8'd9, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'd0,  8'hFF, 8'd0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'd0,  8'hFF, 8'd0, 0, 0, 0, 0));
    // Out-of-range load, sticky error, valid load clears it
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'd12, 8'hFF, 8'd9, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'hFF, 8'd2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'd4,  8'hFF, 8'd4, 0, 0, 0, 0));
    // Compare match through 5
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'd5,  8'd5, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 8'd0,  8'd5,  8'd6, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'd5,  8'd5,  8'd5, 0, 0, 1, 0));
    // Reset beats load; load beats terminal-count wrap
    tbl.push_back(mk(0, 1, 1, 1, 1, 8'd8,  8'hFF, 8'd3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 8'd9,  8'hFF, 8'd9, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 8'd2,  8'hFF, 8'd2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'd0,  8'hFF, 8'd2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 8'd0,  8'hFF, 8'd2, 0, 0, 0, 0));

    @(negedge CLK);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i]);

    // Full-range instance: bounds behaviour differs between modulo and saturating builds
    step(mk(1, 1, 0, 0, 1, 8'd0,  8'd0, 8'd0,  0, 0, 1, 0));
    step(mk(1, 0, 1, 0, 1, 8'd15, 8'd0, 8'd15, 0, 0, 0, 0));
`ifdef COUNTER_SAT_EN
    step(mk(1, 0, 0, 1, 1, 8'd0,  8'd0, 8'd15, 1, 0, 0, 0));
    step(mk(1, 0, 0, 1, 1, 8'd0,  8'd0, 8'd15, 1, 0, 0, 0));
    step(mk(1, 0, 1, 0, 0, 8'd0,  8'd0, 8'd0,  0, 0, 1, 0));
    step(mk(1, 0, 0, 1, 0, 8'd0,  8'd0, 8'd0,  1, 0, 1, 0));
    step(mk(1, 0, 0, 1, 0, 8'd0,  8'd0, 8'd0,  1, 0, 1, 0));
`else
    step(mk(1, 0, 0, 1, 1, 8'd0,  8'd0, 8'd0,  0, 0, 1, 0));
    step(mk(1, 0, 0, 1, 1, 8'd0,  8'd0, 8'd1,  0, 1, 0, 0));
    step(mk(1, 0, 1, 0, 0, 8'd0,  8'd0, 8'd0,  0, 0, 1, 0));
    step(mk(1, 0, 0, 1, 0, 8'd0,  8'd0, 8'd15, 0, 0, 0, 0));
    step(mk(1, 0, 0, 1, 0, 8'd0,  8'd0, 8'd14, 0, 1, 0, 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
